// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared array sizing defaults and the pointer-width helper.
package ofifo_pkg;
  localparam int COL = 8;
  localparam int PSUM_BW = 16;
  function automatic int log2(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/ofifo_fifo_lane.sv
// fifo_lane: one column FIFO with extra-MSB pointers; storage is not reset.
module fifo_lane
  import ofifo_pkg::*;
#(
  parameter int width = PSUM_BW,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [width-1:0] in,
  output logic [width-1:0] out,
  output logic             o_empty,
  output logic             o_full
);
  localparam int aw = log2(depth);
  logic [aw:0] wp_q, wp_d, rp_q, rp_d;
  logic [width-1:0] mem [depth];
  logic do_wr;
  always_comb begin
    o_empty = wp_q == rp_q;
    o_full = (wp_q ^ rp_q) == {1'b1, {aw{1'b0}}};
    do_wr = wr && !o_full;
    wp_d = wp_q + {{aw{1'b0}}, do_wr};
    rp_d = rp_q + {{aw{1'b0}}, rd && !o_empty};
    out = mem[rp_q[aw-1:0]];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wp_q[aw-1:0]] <= in;
endmodule

// File: rtl/ofifo.sv
// ofifo: per-column output FIFOs that deskew array results and pop whole rows.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);
  logic [col-1:0] empty, full;
  logic [psum_bw*col-1:0] head, out_q, out_d;
  logic pop, ovf_q, ovf_d;
  genvar i;
  generate
    for (i = 0; i < col; i++) begin : g_lane
      fifo_lane #(.width(psum_bw), .depth(depth)) u_lane (
        .clk(clk),
        .reset(reset),
        .wr(wr[i]),
        .rd(pop),
        .in(in[psum_bw*i +: psum_bw]),
        .out(head[psum_bw*i +: psum_bw]),
        .o_empty(empty[i]),
        .o_full(full[i])
      );
    end
  endgenerate
  always_comb begin
    o_valid = ~|empty;
    pop = rd && o_valid;
    o_full = |full;
    o_ready = !o_full;
    out_d = pop ? head : out_q;
    ovf_d = ovf_q || |(wr & full);
    out = out_q;
    o_overflow = ovf_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
endmodule

// File: tb/tb_ofifo.sv
// tb_ofifo: vector table, directed corner cases and random traffic against a queue model.
module tb_ofifo;
  localparam int C = 8;
  localparam int W = 16;
  localparam int D = 16;
  logic clk = 0, reset = 1, rd = 0;
  logic [C-1:0] wr = '0;
  logic [W*C-1:0] din = '0, dout;
  logic o_valid, o_full, o_ready, o_overflow;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] q [C][$];
  logic [W*C-1:0] m_out = '0;
  logic m_ovf = 0;

  ofifo #(.col(C), .psum_bw(W), .depth(D)) dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd), .out(dout),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C-1:0] wr;
    logic rd;
    logic [W-1:0] base;
    logic ev;
    logic [W-1:0] eo;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [W*C-1:0] row(input logic [W-1:0] b);
    logic [W*C-1:0] r;
    for (int i = 0; i < C; i++) r[i*W +: W] = b + W'(i);
    return r;
  endfunction

  task automatic chk(input string n, input logic [W*C-1:0] a, input logic [W*C-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic m_valid();
    for (int i = 0; i < C; i++) if (q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < C; i++) if (q[i].size() == D) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < C; i++) q[i].delete();
    m_out = '0;
    m_ovf = 0;
  endtask

  task automatic model_step(input logic [C-1:0] w, input logic r, input logic [W*C-1:0] d);
    logic fl[C];
    logic v;
    v = m_valid();
    for (int i = 0; i < C; i++) fl[i] = q[i].size() == D;
    if (r && v) for (int i = 0; i < C; i++) m_out[i*W +: W] = q[i].pop_front();
    for (int i = 0; i < C; i++)
      if (w[i]) begin
        if (fl[i]) m_ovf = 1;
        else q[i].push_back(d[i*W +: W]);
      end
  endtask

  task automatic check_model();
    chk("out", dout, m_out);
    chk("o_valid", {127'b0, o_valid}, {127'b0, m_valid()});
    chk("o_full", {127'b0, o_full}, {127'b0, m_full()});
    chk("o_ready", {127'b0, o_ready}, {127'b0, !m_full()});
    chk("o_overflow", {127'b0, o_overflow}, {127'b0, m_ovf});
  endtask

  task automatic cyc(input logic [C-1:0] w, input logic r, input logic [W*C-1:0] d);
    wr = w;
    rd = r;
    din = d;
    @(posedge clk);
    model_step(w, r, d);
    #1 check_model();
  endtask

  task automatic pulse_reset();
    reset = 1;
    wr = '1;
    din = row(16'hbad0);
    #1;
    model_reset();
    chk("rst_valid", {127'b0, o_valid}, 128'd0);
    chk("rst_out", dout, 128'd0);
    chk("rst_ovf", {127'b0, o_overflow}, 128'd0);
    chk("rst_full", {127'b0, o_full}, 128'd0);
    chk("rst_ready", {127'b0, o_ready}, 128'd1);
    @(posedge clk);
    #1 reset = 0;
    wr = '0;
  endtask

  initial begin
    logic [W*C-1:0] exp_row, saved;
    int pops;
    tbl[0] = '{8'hFF, 1'b0, 16'h0001, 1'b1, 16'h0000};
    tbl[1] = '{8'h00, 1'b1, 16'h0001, 1'b0, 16'h0001};
    for (int k = 0; k < 8; k++) tbl[2+k] = '{8'(1 << k), 1'b0, 16'h0100, k == 7, 16'h0001};
    tbl[10] = '{8'h00, 1'b1, 16'h0100, 1'b0, 16'h0100};

    model_reset();
    #12;
    chk("init_valid", {127'b0, o_valid}, 128'd0);
    chk("init_out", dout, 128'd0);
    chk("init_ready", {127'b0, o_ready}, 128'd1);
    @(negedge clk) reset = 0;

    foreach (tbl[n]) begin
      cyc(tbl[n].wr, tbl[n].rd, row(tbl[n].base));
      chk($sformatf("tbl%0d_valid", n), {127'b0, o_valid}, {127'b0, tbl[n].ev});
      chk($sformatf("tbl%0d_out", n), dout, tbl[n].eo == 0 ? '0 : row(tbl[n].eo));
    end

    for (int n = 0; n < D; n++) cyc('1, 0, row(16'h1000 + 16'(n * 16)));
    chk("full_flag", {127'b0, o_full}, 128'd1);
    chk("full_ready", {127'b0, o_ready}, 128'd0);
    cyc('1, 1, row(16'hdea0));
    chk("drop_ovf", {127'b0, o_overflow}, 128'd1);
    chk("drop_head", dout, row(16'h1000));
    pops = 0;
    while (o_valid && pops < 20) begin
      cyc('0, 1, '0);
      pops++;
    end
    chk("occupancy", 128'(pops), 128'd15);

    pulse_reset();
    cyc('1, 0, row(16'h2000));
    for (int n = 1; n <= 40; n++) cyc('1, 1, row(16'h2000 + 16'(n * 8)));
    chk("wrap_last", dout, row(16'h2000 + 16'(39 * 8)));
    chk("wrap_ovf", {127'b0, o_overflow}, 128'd0);
    cyc('0, 1, '0);

    cyc(8'hF7, 0, row(16'h3000));
    saved = dout;
    cyc('0, 1, '0);
    chk("empty3_hold", dout, saved);
    cyc(8'h08, 0, row(16'h4000));
    cyc('0, 1, '0);
    exp_row = row(16'h3000);
    exp_row[3*W +: W] = 16'h4003;
    chk("empty3_row", dout, exp_row);

    for (int n = 0; n < 400; n++)
      cyc(C'($urandom), $urandom_range(0, 9) < 3, {$urandom, $urandom, $urandom, $urandom});

    for (int n = 0; n < 5; n++) cyc('1, 0, row(16'h5000 + 16'(n * 8)));
    #2;
    pulse_reset();
    cyc('1, 0, row(16'h6000));
    cyc('0, 1, '0);
    chk("post_rst_row", dout, row(16'h6000));
    chk("post_rst_valid", {127'b0, o_valid}, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
